// File: rtl/audvid_pkg.sv
// Shared constants and state encoding for the audvid audio blocks.
package audvid_pkg;

  localparam int AUDIO_SAMPLE_WIDTH  = 16;
  localparam int I2S_SLOTS_PER_FRAME = 32;
  localparam int UNDERRUN_CNT_WIDTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/audvid_sample_fifo.sv
// Stereo-frame FIFO with occupancy counter; a push is allowed into a full FIFO
// only when a pop frees a slot in the same cycle.
module audvid_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_full_nxt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count, w_count_nxt;
  logic             w_wr, w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_rdata = r_mem[r_rptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + 1'b1;
    else if (!w_wr && w_rd) w_count_nxt = r_count - 1'b1;
  end

  // Lets the parent register its ready flag with the post-edge occupancy.
  assign o_full_nxt = (w_count_nxt == FULL_CNT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/audvid_i2s_transmitter.sv
// Philips I2S transmitter: frame FIFO feeding a 32-slot serializer with underrun
// tracking. Slot 31 is the frame boundary; IDLE parks the slot counter there.
module audvid_i2s_transmitter
  import audvid_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          I2SCLK,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          Mute,
  input  logic                          SampleValid,
  output logic                          SampleReady,
  input  logic [SAMPLE_WIDTH-1:0]       SampleLeft,
  input  logic [SAMPLE_WIDTH-1:0]       SampleRight,
  output logic                          I2S_LRCK,
  output logic                          I2S_SDATA,
  output logic                          Underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0] UnderrunCount
);
  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int CW = $clog2(I2S_SLOTS_PER_FRAME);
  localparam logic [CW-1:0] LAST_SLOT = CW'(I2S_SLOTS_PER_FRAME - 1);
  localparam logic [CW-1:0] LR_FIRST  = CW'(I2S_SLOTS_PER_FRAME / 2 - 1);
  localparam logic [CW-1:0] LR_LAST   = CW'(I2S_SLOTS_PER_FRAME - 2);

  state_t                        r_state, w_state_nxt;
  logic [CW-1:0]                 r_bitcnt, w_bitcnt_nxt;
  logic [FW-1:0]                 r_shift, w_frame, w_rdata;
  logic                          r_lrck, r_sdata, r_ready, r_primed, r_underrun;
  logic [UNDERRUN_CNT_WIDTH-1:0] r_urcnt;
  logic                          w_boundary, w_load, w_enter_idle, w_starve;
  logic                          w_push, w_pop, w_full, w_empty, w_full_nxt;

  assign w_boundary = (r_bitcnt == LAST_SLOT);
  assign w_push     = SampleValid && r_ready && !w_full;
  assign w_pop      = w_load;

  audvid_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (I2SCLK),
    .i_rst      (Reset),
    .i_push     (w_push),
    .i_wdata    ({SampleLeft, SampleRight}),
    .i_pop      (w_pop),
    .o_rdata    (w_rdata),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_full_nxt (w_full_nxt)
  );

  always_ff @(posedge I2SCLK or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_boundary) w_state_nxt = Enable ? RUN : IDLE;
  end

  // A frame is loaded only when the next frame will actually be sent.
  always_comb begin
    w_load       = w_boundary && (w_state_nxt == RUN);
    w_enter_idle = (r_state == RUN) && (w_state_nxt == IDLE);
    w_starve     = w_load && w_empty;
    w_frame      = (w_empty || Mute) ? '0 : w_rdata;
    if (w_load)                    w_bitcnt_nxt = '0;
    else if (w_state_nxt == IDLE)  w_bitcnt_nxt = LAST_SLOT;
    else                           w_bitcnt_nxt = r_bitcnt + 1'b1;
  end

  // LRCK is computed from the upcoming slot so it leads data by one bit.
  always_ff @(posedge I2SCLK or posedge Reset) begin
    if (Reset) begin
      r_bitcnt <= LAST_SLOT;
      r_shift  <= '0;
      r_sdata  <= 1'b0;
      r_lrck   <= 1'b0;
    end else begin
      r_bitcnt <= w_bitcnt_nxt;
      r_lrck   <= (w_state_nxt == RUN) && (w_bitcnt_nxt >= LR_FIRST) &&
                  (w_bitcnt_nxt <= LR_LAST);
      if (w_load) begin
        r_sdata <= w_frame[FW-1];
        r_shift <= {w_frame[FW-2:0], 1'b0};
      end else if (w_state_nxt == RUN) begin
        r_sdata <= r_shift[FW-1];
        r_shift <= {r_shift[FW-2:0], 1'b0};
      end else begin
        r_sdata <= 1'b0;
        r_shift <= '0;
      end
    end
  end

  always_ff @(posedge I2SCLK or posedge Reset) begin
    if (Reset) begin
      r_ready    <= 1'b0;
      r_primed   <= 1'b0;
      r_underrun <= 1'b0;
      r_urcnt    <= '0;
    end else begin
      r_ready <= !w_full_nxt;
      if (w_enter_idle)                          r_primed <= 1'b0;
      else if (w_push && (w_state_nxt == RUN))   r_primed <= 1'b1;
      if (w_starve && r_primed) begin
        r_underrun <= 1'b1;
        if (r_urcnt != '1) r_urcnt <= r_urcnt + 1'b1;
      end
    end
  end

  assign SampleReady   = r_ready;
  assign I2S_LRCK      = r_lrck;
  assign I2S_SDATA     = r_sdata;
  assign Underrun      = r_underrun;
  assign UnderrunCount = r_urcnt;

endmodule
